// File: rtl/accu_rr_sched.sv
// Round-robin scheduler sharing one saturating x16 accumulator among N_CH channels.
// Define ACCU_SCHED_PIPE_EN to add an input register stage (latency 2 instead of 1).
module accu_rr_sched #(
    parameter int                     N_CH     = 4,
    parameter int                     IN_WIDTH = 15,
    parameter int                     SIZE     = 26,
    parameter logic signed [SIZE-1:0] LIMIT    = 26'sd18849555,
    localparam int                    CHW      = $clog2(N_CH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            req_valid,
    input  logic [N_CH*IN_WIDTH-1:0]   req_data,
    output logic [N_CH-1:0]            req_ready,
    input  logic [N_CH-1:0]            clr,
    output logic                       out_valid,
    output logic [CHW-1:0]             out_ch,
    output logic signed [SIZE-1:0]     out_accu,
    output logic                       out_sat
);

    localparam logic signed [SIZE:0] LIM_P = {LIMIT[SIZE-1], LIMIT};
    localparam logic signed [SIZE:0] LIM_N = -LIM_P;

    logic [N_CH-1:0]        w_elig;
    logic [N_CH-1:0]        w_grant;
    logic [CHW-1:0]         w_gnt_ch;
    logic                   w_found;
    logic [CHW-1:0]         w_ptr_nxt;
    logic [CHW-1:0]         r_ptr;
    logic signed [SIZE-1:0] r_state [N_CH];

    logic                   w_do;
    logic [CHW-1:0]         w_ch;
    logic [IN_WIDTH-1:0]    w_data;
    logic signed [SIZE:0]   w_inc;
    logic signed [SIZE:0]   w_cur;
    logic signed [SIZE:0]   w_sum;
    logic signed [SIZE:0]   w_res;
    logic                   w_sat;

    logic                   r_out_valid;
    logic [CHW-1:0]         r_out_ch;
    logic signed [SIZE-1:0] r_out_accu;
    logic                   r_out_sat;

    // A channel being cleared is never eligible, so clear and accept cannot collide.
    assign w_elig = req_valid & ~clr;

    always_comb begin
        w_grant  = '0;
        w_gnt_ch = '0;
        w_found  = 1'b0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            int unsigned idx;
            idx = 32'(r_ptr) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!w_found && w_elig[idx]) begin
                w_found      = 1'b1;
                w_grant[idx] = 1'b1;
                w_gnt_ch     = CHW'(idx);
            end
        end
    end

    assign req_ready = w_grant;
    assign w_ptr_nxt = (w_gnt_ch == CHW'(N_CH - 1)) ? '0 : w_gnt_ch + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_ptr_nxt;
        end
    end

`ifdef ACCU_SCHED_PIPE_EN
    logic                r_s1_valid;
    logic [CHW-1:0]      r_s1_ch;
    logic [IN_WIDTH-1:0] r_s1_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_ch    <= '0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_found;
            if (w_found) begin
                r_s1_ch   <= w_gnt_ch;
                r_s1_data <= req_data[w_gnt_ch*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    // A clear arriving while the request sits in stage 1 wins and drops the result.
    assign w_ch   = r_s1_ch;
    assign w_data = r_s1_data;
    assign w_do   = r_s1_valid && !clr[r_s1_ch];
`else
    assign w_ch   = w_gnt_ch;
    assign w_data = req_data[w_gnt_ch*IN_WIDTH +: IN_WIDTH];
    assign w_do   = w_found;
`endif

    assign w_inc = {{(SIZE - 3 - IN_WIDTH){w_data[IN_WIDTH-1]}}, w_data, 4'b0000};
    assign w_cur = {r_state[w_ch][SIZE-1], r_state[w_ch]};
    assign w_sum = w_cur + w_inc;

    always_comb begin
        w_res = w_sum;
        w_sat = 1'b0;
        if (w_sum > LIM_P) begin
            w_res = LIM_P;
            w_sat = 1'b1;
        end else if (w_sum < LIM_N) begin
            w_res = LIM_N;
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_state[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (clr[i]) begin
                    r_state[i] <= '0;
                end else if (w_do && (w_ch == CHW'(i))) begin
                    r_state[i] <= w_res[SIZE-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_accu  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_out_valid <= w_do;
            if (w_do) begin
                r_out_ch   <= w_ch;
                r_out_accu <= w_res[SIZE-1:0];
                r_out_sat  <= w_sat;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_accu  = r_out_accu;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_accu_rr_sched.sv
// Scoreboard bench for accu_rr_sched: directed stimulus pushes expected results,
// a negedge monitor pops and compares each out_valid beat.
module tb_accu_rr_sched;

    localparam int N_CH = 4;
    localparam int IW   = 15;
    localparam int SIZE = 26;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH-1:0]        req_valid;
    logic [N_CH*IW-1:0]     req_data;
    logic [N_CH-1:0]        req_ready;
    logic [N_CH-1:0]        clr;
    logic                   out_valid;
    logic [1:0]             out_ch;
    logic signed [SIZE-1:0] out_accu;
    logic                   out_sat;

    accu_rr_sched #(
        .N_CH     (N_CH),
        .IN_WIDTH (IW),
        .SIZE     (SIZE),
        .LIMIT    (26'sd18849555)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_accu  (out_accu),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int accu;
        bit sat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   last_ch;
    int   last_accu;

    task automatic check(input string nm, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic push(input int ch, input int accu, input bit sat);
        exp_t e;
        e.ch = ch;
        e.accu = accu;
        e.sat = sat;
        exp_q.push_back(e);
        last_ch = ch;
        last_accu = accu;
    endtask

    task automatic set_data(input int ch, input logic [IW-1:0] val);
        req_data[ch*IW +: IW] = val;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got out_valid=1 ch=%0d accu=%0d, expected no result",
                         out_ch, out_accu);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_ch", out_ch, mon_e.ch);
                check("out_accu", out_accu, mon_e.accu);
                check("out_sat", out_sat, mon_e.sat);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    int rr_exp [8] = '{3216, 18587443, 48, 80, 3232, 18587475, 96, 144};

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        clr       = '0;
        #3;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_accu", out_accu, 0);
        check("reset_out_ch", out_ch, 0);
        check("reset_out_sat", out_sat, 0);
        check("reset_req_ready", req_ready, 0);
        step();
        step();
        rst = 1'b0;

        // Two accepts on ch0 with data 100
        req_valid = 4'b0001;
        set_data(0, 15'd100);
        #1;
        check("ready_ch0", req_ready, 4'b0001);
        push(0, 1600, 0);
        push(0, 3200, 0);
        step();
        step();
        req_valid = '0;

        // ch1 ramp to positive saturation, then back down
        req_valid = 4'b0010;
        set_data(1, 15'd16383);
        #1;
        check("ready_ch1", req_ready, 4'b0010);
        for (int k = 1; k <= 71; k++) push(1, k * 262128, 0);
        push(1, 18849555, 1);
        push(1, 18587411, 0);
        repeat (72) step();
        set_data(1, 15'h4000);
        step();
        req_valid = '0;

        // Lone ch3 accept moves the pointer to 0
        req_valid = 4'b1000;
        set_data(3, 15'd1);
        push(3, 16, 0);
        step();

        // All channels valid: strict rotation
        req_valid = 4'b1111;
        set_data(0, 15'd1);
        set_data(1, 15'd2);
        set_data(2, 15'd3);
        set_data(3, 15'd4);
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_grant", req_ready, 4'b0001 << (k % 4));
            push(k % 4, rr_exp[k], 0);
            step();
        end
        req_valid = '0;

        // Clear of ch2 masks it; ch3 is granted instead
        req_valid = 4'b1100;
        clr       = 4'b0100;
        set_data(2, 15'd5);
        set_data(3, 15'd1);
        #1;
        check("clr_mask_grant", req_ready, 4'b1000);
        push(3, 160, 0);
        step();
        clr       = '0;
        req_valid = 4'b0100;
        #1;
        check("after_clr_grant", req_ready, 4'b0100);
        push(2, 80, 0);
        step();
        req_valid = '0;
        repeat (3) step();

        // Asynchronous reset with a result in flight
        req_valid = 4'b0001;
        set_data(0, 15'd7);
        step();
        req_valid = '0;
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_accu", out_accu, 0);
        check("async_rst_out_ch", out_ch, 0);
        check("async_rst_out_sat", out_sat, 0);
        step();
        step();
        rst = 1'b0;
        req_valid = 4'b0011;
        set_data(0, 15'd1);
        set_data(1, 15'd1);
        #1;
        check("post_rst_ptr", req_ready, 4'b0001);
        push(0, 16, 0);
        step();
        check("post_rst_next", req_ready, 4'b0010);
        push(1, 16, 0);
        step();
        req_valid = '0;

`ifdef ACCU_SCHED_PIPE_EN
        repeat (3) step();
        req_valid = 4'b0001;
        set_data(0, 15'd3);
        step();
        req_valid = '0;
        clr       = 4'b0001;
        step();
        clr       = '0;
        req_valid = 4'b0001;
        set_data(0, 15'd2);
        push(0, 32, 0);
        step();
        req_valid = '0;
`endif

        for (int k = 0; k < 20; k++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check("drain_pending", exp_q.size(), 0);
        repeat (2) step();
        check("idle_out_valid", out_valid, 0);
        check("hold_out_ch", out_ch, last_ch);
        check("hold_out_accu", out_accu, last_accu);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/accu_rr_sched.md
# accu_rr_sched

Round-robin scheduler that shares one saturating scaled accumulator datapath between `N_CH` requesters. Each channel keeps its own accumulator state. One request is accepted per cycle. The accepted increment is scaled by 16, added to that channel's state, clamped to ±`LIMIT`, written back and reported on a single result port. The block sits between the per-channel increment sources (phase/error generators) and downstream consumers that need one saturated accumulator value per channel.

## Interface
- `N_CH`, 4: number of requesting channels (2..8).
- `IN_WIDTH`, 15: signed increment width.
- `SIZE`, 26: signed accumulator width.
- `LIMIT`, 26'sd18849555: symmetric saturation bound, must satisfy 0 < `LIMIT` < 2^(SIZE-1).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  N_CH  per-channel request valid.
- `req_data`  in  N_CH*IN_WIDTH  signed increments; channel i occupies bits [i*IN_WIDTH +: IN_WIDTH].
- `req_ready`  out  N_CH  one-hot-or-zero grant, combinational.
- `clr`  in  N_CH  per-channel synchronous clear of accumulator state.
- `out_valid`  out  1  result strobe, one cycle per accepted request.
- `out_ch`  out  clog2(N_CH)  channel of the result.
- `out_accu`  out  SIZE  signed saturated accumulator value after the update.
- `out_sat`  out  1  result was clamped this update.

## Operation
- Handshake: channel i is accepted on an edge where `req_valid[i] && req_ready[i]`. `req_data` must remain stable while valid and not ready.
- Arbiter: `ptr` is a register in 0..N_CH-1.
  - Grant goes to the first i with `req_valid[i] && !clr[i]`, searching from `ptr` upward and wrapping.
  - After an accept of channel g, `ptr <= (g+1) mod N_CH`. With no accept, `ptr` holds.
  - At most one `req_ready` bit is high. Grant is independent of `out_valid` (no backpressure on results).
- Arithmetic:
  - `inc = 16*req_data`, sign-extended to SIZE+1 bits.
  - `sum = state[ch] + inc` in SIZE+1 bits.
  - If `sum > LIMIT`, result is `LIMIT`. If `sum < -LIMIT`, result is `-LIMIT`. Otherwise result is `sum`.
  - `out_sat` is high when either clamp applied.
  - Result is written to `state[ch]` and driven on `out_accu`. The state invariant |state| ≤ LIMIT guarantees no SIZE+1 overflow.
- Clear: `clr[i]` sets `state[i] <= 0` at the edge. It masks channel i from arbitration in the same cycle, so clear and accept of the same channel never coincide. Simultaneous clears of several channels are all applied.
- Reset:
  - `state[*]`, `ptr`, `out_valid`, `out_ch`, `out_accu`, `out_sat` and internal valid bits all go to 0 immediately.
  - In-flight operations are dropped and produce no `out_valid`.

## Timing
- Base build (macro undefined):
  - Accept on edge t. State write-back and `out_*` registered on the same edge t.
  - `out_valid` is high during cycle t..t+1. Latency 1, throughput 1/cycle.
  - Back-to-back accepts of the same channel each see the previous write.
- `out_valid` is low in any cycle following an edge with no accept. `out_ch`, `out_accu` and `out_sat` hold their last values when `out_valid` is low.
- `req_ready` depends combinationally on `req_valid`, `clr` and `ptr` only.

## Configuration
- `ACCU_SCHED_PIPE_EN`: when defined, an input register stage (`s1_valid`, `s1_ch`, `s1_data`) captures the accepted request on edge t.
  - The add/saturate and write-back happen on edge t+1, so `out_valid` is high in cycle t+1..t+2. Latency is 2, throughput stays 1/cycle.
  - Reads of `state[s1_ch]` already include the write made on edge t, so no forwarding path is needed.
  - If `clr[s1_ch]` is high while `s1_valid`, clear wins: state becomes 0, that result is dropped and `out_valid` stays low.
- Without the macro: single-stage behaviour as in Timing, and no `s1_*` registers exist.

## Test plan
- Reset, then ch0 valid with data 100 → ch0 accepted, `out_ch`=0, `out_accu`=1600, `out_sat`=0. A second 100 on ch0 gives 3200.
- ch1 held valid with data 16383 → 71st result is 18611088. 72nd result is clamped to 18849555 with `out_sat`=1. Then data -16384 gives 18587411.
- All four channels continuously valid from `ptr`=0 → grant order 0,1,2,3,0,1…, one `out_valid` per cycle, no channel starves.
- ch2 valid with `clr[2]` high for one cycle → `req_ready[2]`=0 that cycle, ch3 is granted if valid, and `state[2]` reads 0 on its next result (next result = 16*data).
- `rst` asserted asynchronously mid-stream with results pending (both builds) → all outputs 0 immediately, no stale `out_valid` after release, and the next ch0 data 1 returns 16.
- `ACCU_SCHED_PIPE_EN` build: accept ch0 on edge t → `out_valid` appears after edge t+1. `clr[0]` in cycle t..t+1 → no result, `state[0]`=0.
